// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout reader: 640x480@60 VGA timing from a divided system
// clock. Each 320x240 framebuffer pixel is shown as a 2x2 block, with the
// rows flipped so that framebuffer row FB_H-1 is the top display line.
module fb_scanout_reader #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int FB_W     = 320,
   parameter int FB_H     = 240
) (
   input  logic        clk,
   input  logic        rst,
   output logic [16:0] o_fb_r_addr,
   input  logic [11:0] i_fb_r_data,
   output logic [3:0]  o_vga_r,
   output logic [3:0]  o_vga_g,
   output logic [3:0]  o_vga_b,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_blank,
   output logic        o_frame_start
);
   localparam int ADDR_W  = 17;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);
   localparam int HC_W    = $clog2(H_TOTAL + 1);
   localparam int VC_W    = $clog2(V_TOTAL + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [HC_W-1:0]   HC_LAST  = HC_W'(H_TOTAL - 1);
   localparam logic [VC_W-1:0]   VC_LAST  = VC_W'(V_TOTAL - 1);
   localparam logic [HC_W-1:0]   HA_C     = HC_W'(H_ACTIVE);
   localparam logic [VC_W-1:0]   VA_C     = VC_W'(V_ACTIVE);
   localparam logic [VC_W-1:0]   VA_M1    = VC_W'(V_ACTIVE - 1);
   localparam logic [HC_W-1:0]   HS_BEG   = HC_W'(H_ACTIVE + H_FP);
   localparam logic [HC_W-1:0]   HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VC_W-1:0]   VS_BEG   = VC_W'(V_ACTIVE + V_FP);
   localparam logic [VC_W-1:0]   VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [ADDR_W-1:0] ROW_INIT = ADDR_W'((FB_H - 1) * FB_W);
   localparam logic [ADDR_W-1:0] FBW_C    = ADDR_W'(FB_W);

   logic [DIV_W-1:0]  r_div;
   logic [HC_W-1:0]   r_hc;
   logic [VC_W-1:0]   r_vc;
   logic [ADDR_W-1:0] r_row_base;
   logic              r_tick_d;

   logic              w_tick;
   logic              w_hc_wrap;
   logic              w_active;
   logic [ADDR_W-1:0] w_col;

   assign w_tick    = (r_div == DIV_LAST);
   assign w_hc_wrap = (r_hc == HC_LAST);
   assign w_active  = (r_hc < HA_C) && (r_vc < VA_C);
   assign w_col     = ADDR_W'(r_hc[HC_W-1:1]);

   // Pixel-enable divider: one tick every CLK_DIV system clocks
   always_ff @(posedge clk) begin
      if (rst)         r_div <= '0;
      else if (w_tick) r_div <= '0;
      else             r_div <= r_div + 1'b1;
   end

   // Horizontal / vertical position counters, advanced once per pixel tick
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (w_tick) begin
         if (w_hc_wrap) begin
            r_hc <= '0;
            r_vc <= (r_vc == VC_LAST) ? '0 : r_vc + 1'b1;
         end else begin
            r_hc <= r_hc + 1'b1;
         end
      end
   end

   // Row base walks down one framebuffer row after every second active line
   // (Y flip); reloaded at the top of each frame, so no multiply is needed
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_base <= ROW_INIT;
      end else if (w_tick && w_hc_wrap) begin
         if (r_vc == VC_LAST)
            r_row_base <= ROW_INIT;
         else if (r_vc[0] && (r_vc < VA_M1))
            r_row_base <= r_row_base - FBW_C;
      end
   end

   // Address issued one clk after the tick so BRAM data settles before the
   // next tick; held outside the active area to stay inside the buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_d    <= 1'b0;
         o_fb_r_addr <= ROW_INIT;
      end else begin
         r_tick_d <= w_tick;
         if (r_tick_d && w_active)
            o_fb_r_addr <= r_row_base + w_col;
      end
   end

   // Output stage: registers the position that was current up to this tick
   always_ff @(posedge clk) begin
      if (rst) begin
         o_vga_r       <= '0;
         o_vga_g       <= '0;
         o_vga_b       <= '0;
         o_hsync       <= 1'b1;
         o_vsync       <= 1'b1;
         o_blank       <= 1'b1;
         o_frame_start <= 1'b0;
      end else begin
         o_frame_start <= w_tick && (r_hc == '0) && (r_vc == '0);
         if (w_tick) begin
            {o_vga_r, o_vga_g, o_vga_b} <= w_active ? i_fb_r_data : 12'h000;
            o_blank <= !w_active;
            o_hsync <= !((r_hc >= HS_BEG) && (r_hc < HS_END));
            o_vsync <= !((r_vc >= VS_BEG) && (r_vc < VS_END));
         end
      end
   end
endmodule
